serial_out: RTL and testbench
=============================

// Module: serial_out
// PURPOSE
//  - UART transmitter: serialises one byte per frame onto tx_d.
//  - Frame: start 0, 8 data bits LSB first, optional parity, STOP_BITS stop 1s; 8N1 by default.
//  - Produces frames in the same format the serial input path accepts; sits in the SPI-to-serial return path.
// PARAMETERS
//  - CLKS_PER_BIT  1302  clk_50 cycles per bit (50 MHz / 38400 baud); legal range 2..65535
//  - STOP_BITS     1     number of stop bits; legal values 1 or 2
// PORTS
//  - clk_50    in   1  system clock, 50 MHz; the only clock
//  - rst       in   1  reset, synchronous and active-high
//  - tx_valid  in   1  byte offered on tx_data
//  - tx_data   in   8  byte to send; sampled only at acceptance
//  - tx_ready  out  1  1 = idle and able to accept a byte
//  - tx_d      out  1  serial line; idles high
//  - busy      out  1  1 = frame in progress (always ~tx_ready)
// BEHAVIOUR
//  - Reset, sampled at a clk_50 edge while rst=1:
//    - tx_d=1, tx_ready=1, busy=0.
//    - State IDLE; bit counter = 0; baud counter = 0.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - Acceptance: tx_valid & tx_ready at a clk_50 edge.
//    - tx_data is copied into the shift register.
//    - At the next edge: tx_ready=0, busy=1, tx_d=0 (start bit). Latency from acceptance to start bit is 1 cycle.
//  - Bit timing: every bit is held for exactly CLKS_PER_BIT cycles.
//    - A 0..CLKS_PER_BIT-1 baud counter restarts at each bit boundary.
//    - No drift across a frame.
//  - DATA: bit i = tx_data[i], i = 0..7; a 3-bit counter stops after bit 7.
//  - STOP: tx_d=1 for STOP_BITS*CLKS_PER_BIT cycles.
//    - On the final cycle of STOP, tx_ready goes to 1 for the next edge.
//    - The frame is (10 + STOP_BITS - 1 [+1 parity]) * CLKS_PER_BIT cycles.
//  - Back-to-back: if tx_valid=1 on the first cycle tx_ready=1, the byte is accepted.
//    - The next start bit directly follows the last stop bit; zero idle gap.
//  - While busy:
//    - tx_valid is ignored.
//    - tx_data changes have no effect on the frame in flight.
//  - Reset mid-frame: the frame aborts. At the next edge tx_d=1 and tx_ready=1; there is no partial stop bit.
//  - tx_valid held at 0: stay in IDLE with tx_d=1 indefinitely.
//  - tx_d is driven directly from a register; no combinational path to the pin.
// CONFIGURATION
//  - Macro SERIAL_OUT_PARITY_EN.
//  - Defined:
//    - A PARITY state follows DATA; tx_d = ^tx_data (even parity) for CLKS_PER_BIT cycles.
//    - Frame = 11 + STOP_BITS - 1 bit times.
//  - Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.
// STRUCTURE
//  - Package serial_pkg:
//    - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
//    - Constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
//  - Sub-module baud_tick_gen (CLKS_PER_BIT):
//    - Inputs clk_50, rst, clear.
//    - Output tick: one-cycle pulse when the count reaches CLKS_PER_BIT-1.
//    - clear restarts the count at acceptance.
//  - Top: FSM, 8-bit shift register, bit counter, stop-bit counter.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  - Reset then idle 50 cycles -> tx_d=1, tx_ready=1, busy=0 for every cycle.
//  - Send 8'hA5 -> tx_d: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_ready=0 for 40 cycles, then 1.
//  - Two bytes 8'h00 and 8'hFF with tx_valid held -> 80 contiguous cycles. Second start bit at cycle 40 after the first start; no gap.
//  - tx_valid pulsed with 8'h3C mid-frame of 8'h81 -> ignored; only 8'h81 transmitted.
//  - rst asserted during bit 4 of 8'h55 -> next cycle tx_d=1, tx_ready=1. A new 8'h12 then sends cleanly.
//  - SERIAL_OUT_PARITY_EN, STOP_BITS=2, send 8'h07 -> parity bit 1, then 8 cycles high. Total 48 cycles.
//  - Default CLKS_PER_BIT=1302 -> the 8'h41 start bit lasts exactly 1302 cycles.
//  - Every run: loop tx_d through the serial input path -> the decoded byte matches the sent byte.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial_out UART transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter for serial_out: pulses o_tick on the last cycle of each bit and
// o_pre_tick one cycle earlier so the parent can register look-ahead outputs.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 1302
) (
    input  logic i_clk_50,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_COUNT  = 16'(CLKS_PER_BIT - 2);

    logic [15:0] r_count;

    // Free-running 0..CLKS_PER_BIT-1 count, held at zero while cleared
    always_ff @(posedge i_clk_50) begin
        if (i_rst || i_clear) begin
            r_count <= 16'd0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_tick     = (r_count == LAST_COUNT);
    assign o_pre_tick = (r_count == PRE_COUNT);

endmodule

// File: rtl/serial_out.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Optional parity bit is enabled by defining SERIAL_OUT_PARITY_EN.
module serial_out
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1302,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk_50,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_tx_d,
    output logic       o_busy
);

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx_d;
    logic                 r_ready;
    logic                 r_busy;
    logic                 w_tx_d_next;
    logic                 w_ready_next;
    logic                 w_tick;
    logic                 w_pre_tick;
    logic                 w_clear;
    logic                 w_accept;
    logic                 w_last_stop;
`ifdef SERIAL_OUT_PARITY_EN
    logic                 r_parity;
`endif

    assign w_accept    = i_tx_valid & r_ready;
    assign w_last_stop = (r_stop_cnt == LAST_STOP);
    assign w_clear     = (r_state == IDLE) | w_accept;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk_50  (i_clk_50),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .o_tick    (w_tick),
        .o_pre_tick(w_pre_tick)
    );

    // State register
    always_ff @(posedge i_clk_50) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = START;
                else          w_state_next = IDLE;
            end
            START: begin
                if (w_tick) w_state_next = DATA;
                else        w_state_next = START;
            end
            DATA: begin
                if (w_tick && (r_bit_cnt == 3'd7)) begin
`ifdef SERIAL_OUT_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end else begin
                    w_state_next = DATA;
                end
            end
            PARITY: begin
                if (w_tick) w_state_next = STOP;
                else        w_state_next = PARITY;
            end
            STOP: begin
                // Accepting on the last stop cycle chains the next frame with no idle gap
                if (w_tick && w_last_stop) begin
                    if (w_accept) w_state_next = START;
                    else          w_state_next = IDLE;
                end else begin
                    w_state_next = STOP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered line and handshake outputs
    always_comb begin
        w_tx_d_next  = r_tx_d;
        w_ready_next = r_ready;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tx_d_next  = START_LEVEL;
                    w_ready_next = 1'b0;
                end else begin
                    w_tx_d_next  = IDLE_LEVEL;
                    w_ready_next = 1'b1;
                end
            end
            START: begin
                if (w_tick) w_tx_d_next = r_shift[0];
                else        w_tx_d_next = r_tx_d;
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef SERIAL_OUT_PARITY_EN
                        w_tx_d_next = r_parity;
`else
                        w_tx_d_next = IDLE_LEVEL;
`endif
                    end else begin
                        w_tx_d_next = r_shift[1];
                    end
                end else begin
                    w_tx_d_next = r_tx_d;
                end
            end
            PARITY: begin
                if (w_tick) w_tx_d_next = IDLE_LEVEL;
                else        w_tx_d_next = r_tx_d;
            end
            STOP: begin
                if (w_tick && w_last_stop) begin
                    if (w_accept) begin
                        w_tx_d_next  = START_LEVEL;
                        w_ready_next = 1'b0;
                    end else begin
                        w_tx_d_next  = IDLE_LEVEL;
                        w_ready_next = 1'b1;
                    end
                end else if (w_pre_tick && w_last_stop) begin
                    w_ready_next = 1'b1;
                end else begin
                    w_ready_next = r_ready;
                end
            end
            default: begin
                w_tx_d_next  = IDLE_LEVEL;
                w_ready_next = 1'b1;
            end
        endcase
    end

    // Output registers, shift register and bit/stop counters
    always_ff @(posedge i_clk_50) begin
        if (i_rst) begin
            r_tx_d     <= IDLE_LEVEL;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx_d  <= w_tx_d_next;
            r_ready <= w_ready_next;
            r_busy  <= ~w_ready_next;
            if (w_accept) begin
                r_shift    <= i_tx_data;
                r_bit_cnt  <= 3'd0;
                r_stop_cnt <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
                r_parity   <= ^i_tx_data;
`endif
            end else if ((r_state == DATA) && w_tick) begin
                r_shift <= r_shift >> 1;
                if (r_bit_cnt != 3'd7) r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if ((r_state == STOP) && w_tick && !w_last_stop) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

    assign o_tx_d     = r_tx_d;
    assign o_tx_ready = r_ready;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out: three instances (4 clk/bit 1 stop, 4 clk/bit 2 stop, default timing).
// Honours SERIAL_OUT_PARITY_EN when it is defined for the build.
module tb_serial_out;

`ifdef SERIAL_OUT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_A = (10 + int'(PAR)) * 4;
    localparam int FRAME_B = (11 + int'(PAR)) * 4;
    localparam int CPB_C   = 1302;
    localparam int NBITS_C = 10 + int'(PAR);

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, c_valid;
    logic [7:0] a_data, b_data, c_data;
    logic       a_ready, a_tx, a_busy;
    logic       b_ready, b_tx, b_busy;
    logic       c_ready, c_tx, c_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] cap_tx, cap_rdy, cap_busy, first_tx;
    logic [15:0] rxv;
    logic [11:0] deci;
    int          bad, low;
    bit          done, rdy_early, rdy_last;

    always #5 clk = ~clk;

    serial_out #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .i_clk_50(clk), .i_rst(rst), .i_tx_valid(a_valid), .i_tx_data(a_data),
        .o_tx_ready(a_ready), .o_tx_d(a_tx), .o_busy(a_busy));

    serial_out #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
        .i_clk_50(clk), .i_rst(rst), .i_tx_valid(b_valid), .i_tx_data(b_data),
        .o_tx_ready(b_ready), .o_tx_d(b_tx), .o_busy(b_busy));

    serial_out u_c (
        .i_clk_50(clk), .i_rst(rst), .i_tx_valid(c_valid), .i_tx_data(c_data),
        .o_tx_ready(c_ready), .o_tx_d(c_tx), .o_busy(c_busy));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level per cycle for a 4-clk/bit frame
    function automatic logic [63:0] exp_tx(input logic [7:0] d, input int ncyc);
        logic [63:0] v;
        int k;
        v = 64'd0;
        for (int c = 0; c < ncyc; c++) begin
            k = c / 4;
            if (k == 0)                v[c] = 1'b0;
            else if (k <= 8)           v[c] = d[3'(k - 1)];
            else if (PAR && (k == 9))  v[c] = ^d;
            else                       v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_rdy(input int nframe, input int ncyc);
        logic [63:0] v;
        v = 64'd0;
        for (int c = 0; c < ncyc; c++) v[c] = (c >= nframe - 1);
        return v;
    endfunction

    function automatic logic [63:0] mask(input int ncyc);
        logic [63:0] v;
        v = 64'd0;
        for (int c = 0; c < ncyc; c++) v[c] = 1'b1;
        return v;
    endfunction

    // Receiver model: sample the middle of each data bit
    function automatic logic [7:0] rx_decode(input logic [63:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[4 * (k + 1) + 2];
        return r;
    endfunction

    task automatic capture(input bit sel, input int n, input int poke_at, input logic [7:0] poke_d);
        cap_tx = 64'd0; cap_rdy = 64'd0; cap_busy = 64'd0;
        for (int c = 0; c < n; c++) begin
            cap_tx[c]   = sel ? b_tx    : a_tx;
            cap_rdy[c]  = sel ? b_ready : a_ready;
            cap_busy[c] = sel ? b_busy  : a_busy;
            if ((poke_at >= 0) && (c == poke_at)) begin
                a_valid = 1'b1;
                a_data  = poke_d;
            end else if ((poke_at >= 0) && (c == poke_at + 1)) begin
                a_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic start_a(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        step();
        a_valid = 1'b0;
        a_data  = ~d;
    endtask

    task automatic check_frame_a(input string tag, input logic [7:0] d);
        chk({tag, "_tx"},   cap_tx,   exp_tx(d, FRAME_A));
        chk({tag, "_rdy"},  cap_rdy,  exp_rdy(FRAME_A, FRAME_A));
        chk({tag, "_busy"}, cap_busy, ~exp_rdy(FRAME_A, FRAME_A) & mask(FRAME_A));
        chk({tag, "_rx"},   {56'd0, rx_decode(cap_tx)}, {56'd0, d});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
        repeat (3) step();
        chk("rst_tx",    {63'd0, a_tx},    64'd1);
        chk("rst_ready", {63'd0, a_ready}, 64'd1);
        chk("rst_busy",  {63'd0, a_busy},  64'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(a_tx === 1'b1 && a_ready === 1'b1 && a_busy === 1'b0 &&
                  b_tx === 1'b1 && c_tx === 1'b1 && c_ready === 1'b1)) bad++;
            step();
        end
        chk("idle50", 64'(bad), 64'd0);

        // Single byte 8'hA5
        start_a(8'hA5);
        capture(1'b0, FRAME_A, -5, 8'h00);
        check_frame_a("a5", 8'hA5);
        for (int k = 0; k < 9; k++) deci[k] = cap_tx[4 * k + 2];
        chk("a5_bits", {55'd0, deci[8:0]}, 64'h14A);
        chk("a5_end_tx",    {63'd0, a_tx},    64'd1);
        chk("a5_end_ready", {63'd0, a_ready}, 64'd1);

        // Back-to-back 8'h00 then 8'hFF with tx_valid held
        a_valid = 1'b1;
        a_data  = 8'h00;
        step();
        a_data = 8'hFF;
        capture(1'b0, FRAME_A, -5, 8'h00);
        a_valid = 1'b0;
        first_tx = cap_tx;
        chk("b2b1_tx",  first_tx, exp_tx(8'h00, FRAME_A));
        chk("b2b1_rdy", cap_rdy,  exp_rdy(FRAME_A, FRAME_A));
        capture(1'b0, FRAME_A, -5, 8'h00);
        chk("b2b2_start", {63'd0, cap_tx[0]}, 64'd0);
        check_frame_a("b2b2", 8'hFF);

        // Mid-frame tx_valid pulse must be ignored
        start_a(8'h81);
        capture(1'b0, FRAME_A, 10, 8'h3C);
        check_frame_a("ign81", 8'h81);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (!(a_tx === 1'b1 && a_ready === 1'b1)) bad++;
            step();
        end
        chk("ign_idle", 64'(bad), 64'd0);

        // Reset during data bit 4 of 8'h55, then a clean 8'h12
        start_a(8'h55);
        repeat (21) step();
        chk("mid_busy_pre", {63'd0, a_busy}, 64'd1);
        rst = 1'b1;
        step();
        chk("abort_tx",    {63'd0, a_tx},    64'd1);
        chk("abort_ready", {63'd0, a_ready}, 64'd1);
        chk("abort_busy",  {63'd0, a_busy},  64'd0);
        rst = 1'b0;
        step();
        start_a(8'h12);
        capture(1'b0, FRAME_A, -5, 8'h00);
        check_frame_a("after_rst12", 8'h12);

        // Two stop bits (and parity when enabled), byte 8'h07
        b_valid = 1'b1;
        b_data  = 8'h07;
        step();
        b_valid = 1'b0;
        b_data  = 8'hF8;
        capture(1'b1, 48, -5, 8'h00);
        chk("p07_tx",  cap_tx,  exp_tx(8'h07, 48));
        chk("p07_rdy", cap_rdy, exp_rdy(FRAME_B, 48));
        for (int k = 0; k < 12; k++) deci[k] = cap_tx[4 * k + 2];
        chk("p07_bits", {52'd0, deci}, 64'hE0E);
        chk("p07_rx", {56'd0, rx_decode(cap_tx)}, 64'h07);

        // Default timing: start bit of 8'h41 lasts 1302 cycles
        c_valid = 1'b1;
        c_data  = 8'h41;
        step();
        c_valid = 1'b0;
        c_data  = 8'h00;
        low = 0; done = 1'b0; rxv = 16'd0; rdy_early = 1'b0; rdy_last = 1'b0;
        for (int c = 0; c < NBITS_C * CPB_C; c++) begin
            if (!done) begin
                if (c_tx === 1'b0) low++;
                else done = 1'b1;
            end
            if ((c % CPB_C) == CPB_C / 2) rxv[c / CPB_C] = c_tx;
            if (c == NBITS_C * CPB_C - 2) rdy_early = c_ready;
            if (c == NBITS_C * CPB_C - 1) rdy_last = c_ready;
            step();
        end
        chk("c_start_len", 64'(low), 64'd1302);
        chk("c_rx",        {56'd0, rxv[8:1]}, 64'h41);
        chk("c_stop",      {63'd0, rxv[NBITS_C - 1]}, 64'd1);
        chk("c_rdy_early", {63'd0, rdy_early}, 64'd0);
        chk("c_rdy_last",  {63'd0, rdy_last},  64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
